// File: rtl/riscv_jump_pred_pkg.sv
// riscv_jump_pred_pkg: shared issue-FSM states and queue-entry layout for the jump-inject queue.
package riscv_jump_pred_pkg;
    localparam int MAX_ADDR_WIDTH = 64;
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DRAIN} state_e;
    typedef struct packed {
        logic                      valid;
        logic [MAX_ADDR_WIDTH-1:0] addr;
    } entry_t;
endpackage

// File: rtl/riscv_jump_inject_fifo.sv
// riscv_jump_inject_fifo: circular target store with in-place invalidation, duplicate compare and head skipping.
module riscv_jump_inject_fifo
    import riscv_jump_pred_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic                  inv_en,
    input  logic [ADDR_WIDTH-1:0] inv_addr,
    input  logic                  pop,
    output logic                  full,
    output logic                  dup,
    output logic                  head_valid,
    output logic [ADDR_WIDTH-1:0] head_addr
);
    localparam int PW = $clog2(DEPTH);
    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
    // Full means the slot about to be written still holds a live entry.
    assign full       = mem_q[tail_q].valid;
    assign head_valid = mem_q[head_q].valid;
    assign head_addr  = mem_q[head_q].addr[ADDR_WIDTH-1:0];
    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            dup = dup | (mem_q[i].valid && mem_q[i].addr[ADDR_WIDTH-1:0] == wr_addr);
    end
    always_comb begin
        mem_d  = mem_q;
        head_d = head_q;
        tail_d = tail_q;
        for (int i = 0; i < DEPTH; i++)
            if (inv_en && mem_q[i].valid && mem_q[i].addr[ADDR_WIDTH-1:0] == inv_addr)
                mem_d[i].valid = 1'b0;
        if (pop)
            mem_d[head_q].valid = 1'b0;
        if (wr_en) begin
            mem_d[tail_q] = '{valid: 1'b1, addr: MAX_ADDR_WIDTH'(wr_addr)};
            tail_d        = tail_q + 1'b1;
        end
        if (pop || (!mem_q[head_q].valid && head_q != tail_q))
            head_d = head_q + 1'b1;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++)
                mem_d[i].valid = 1'b0;
            head_d = '0;
            tail_d = '0;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            mem_q  <= mem_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end
endmodule

// File: rtl/riscv_jump_inject_queue.sv
// riscv_jump_inject_queue: queues jump-predictor targets and issues them as prefetch req/ack transactions.
module riscv_jump_inject_queue
    import riscv_jump_pred_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  i_stall,
    input  logic                  i_flush,
    input  logic [ADDR_WIDTH-1:0] i_fetch_pc,
    output logic [ADDR_WIDTH-1:0] o_pm_pc,
    input  logic                  i_inject,
    input  logic [ADDR_WIDTH-1:0] i_inject_addr,
    output logic                  o_pref_req,
    output logic [ADDR_WIDTH-1:0] o_pref_addr,
    input  logic                  i_pref_ack,
    output logic [CNT_WIDTH-1:0]  o_issued_cnt,
    output logic [CNT_WIDTH-1:0]  o_dropped_cnt
);
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pref_addr_q, pref_addr_d, last_pc_q, last_pc_d;
    logic [CNT_WIDTH-1:0]  issued_q, issued_d, dropped_q, dropped_d;
    logic                  full, dup, head_valid, in_flight, accept, push, drop, pop;
    logic [ADDR_WIDTH-1:0] head_addr;
    // A prediction that targets the current PC is already stale and never enters the queue.
    assign in_flight = state_q != ST_IDLE && i_inject_addr == pref_addr_q;
    assign accept    = enable && i_inject && i_fetch_pc != last_pc_q && !i_flush &&
                       !dup && !in_flight && i_inject_addr != i_fetch_pc;
    assign push      = accept && !full;
    assign drop      = accept && full;
    assign pop       = state_q == ST_IDLE && enable && !i_stall && !i_flush && head_valid;
    riscv_jump_inject_fifo #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (i_flush),
        .wr_en      (push),
        .wr_addr    (i_inject_addr),
        .inv_en     (enable),
        .inv_addr   (i_fetch_pc),
        .pop        (pop),
        .full       (full),
        .dup        (dup),
        .head_valid (head_valid),
        .head_addr  (head_addr)
    );
    always_comb begin
        state_d     = state_q;
        pref_addr_d = pref_addr_q;
        issued_d    = issued_q;
        dropped_d   = (drop && dropped_q != '1) ? dropped_q + 1'b1 : dropped_q;
        last_pc_d   = enable ? i_fetch_pc : last_pc_q;
        unique case (state_q)
            ST_IDLE: if (pop) begin
                state_d     = ST_REQ;
                pref_addr_d = head_addr;
            end
            ST_REQ: if (i_pref_ack) begin
                state_d  = ST_IDLE;
                issued_d = (!i_flush && issued_q != '1) ? issued_q + 1'b1 : issued_q;
            end else if (i_flush) begin
                state_d = ST_DRAIN;
            end
            ST_DRAIN: state_d = i_pref_ack ? ST_IDLE : ST_DRAIN;
            default:  state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pref_addr_q <= '0;
            last_pc_q   <= '0;
            issued_q    <= '0;
            dropped_q   <= '0;
        end else begin
            state_q     <= state_d;
            pref_addr_q <= pref_addr_d;
            last_pc_q   <= last_pc_d;
            issued_q    <= issued_d;
            dropped_q   <= dropped_d;
        end
    end
    assign o_pm_pc       = i_fetch_pc;
    assign o_pref_req    = state_q != ST_IDLE;
    assign o_pref_addr   = pref_addr_q;
    assign o_issued_cnt  = issued_q;
    assign o_dropped_cnt = dropped_q;
endmodule

// File: doc/riscv_jump_inject_queue.md
Name: riscv_jump_inject_queue

Overview:
- Consumer end of the next-strategy/program-memory interface: drives the current fetch PC to a jump-predictor strategy and takes its inject/inject-address outputs.
- Buffers predicted target addresses in a small queue, removes duplicates and stale entries, and issues them one at a time as prefetch requests to program memory over a req/ack handshake.
- Sits between the fetch stage and program memory; built only when USE_JUMP_PREDICTOR is defined.

Parameters:
- ADDR_WIDTH, 64, width of PC and target addresses
- DEPTH, 4, number of queue entries; power of two, 2..16
- CNT_WIDTH, 16, width of the saturating statistics counters

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  block enable; when low, no capture, no invalidation and no new issue
- i_stall  in  1  pipeline stall; blocks new prefetch issue only
- i_flush  in  1  pipeline redirect; clears all queued entries
- i_fetch_pc  in  ADDR_WIDTH  current fetch PC
- o_pm_pc  out  ADDR_WIDTH  PC presented to the strategy; equals i_fetch_pc (combinational)
- i_inject  in  1  strategy requests injection of a target
- i_inject_addr  in  ADDR_WIDTH  predicted target address
- o_pref_req  out  1  prefetch request valid
- o_pref_addr  out  ADDR_WIDTH  prefetch address; stable while o_pref_req is high
- i_pref_ack  in  1  program memory accepts the request
- o_issued_cnt  out  CNT_WIDTH  acknowledged prefetches, not counting discarded ones; saturating
- o_dropped_cnt  out  CNT_WIDTH  predictions rejected because the queue was full; saturating

Behaviour:
- Reset (async): all entry valid bits 0, head/tail 0, last_pc 0, FSM IDLE, o_pref_req 0, o_pref_addr 0, both counters 0.
- Capture: a new prediction is an enable && i_inject cycle where i_fetch_pc != last_pc. last_pc <= i_fetch_pc whenever enable is high.
- Duplicate handling: a new prediction whose address equals any valid entry, or the address currently being requested, is discarded silently. It is not counted.
- Queue full: full is evaluated before any pop in the same cycle. A non-duplicate prediction into a full queue is dropped and o_dropped_cnt increments.
- Otherwise the prediction is written at tail with valid=1, and tail advances modulo DEPTH.
- Stale invalidation: each cycle with enable high, any valid entry whose address equals i_fetch_pc is cleared in place. A prediction arriving in that same cycle with address == i_fetch_pc is not enqueued.
- Head maintenance: if the head slot is invalid and head != tail, head advances by one per cycle. Empty is head == tail with the head slot invalid.
- Issue FSM:
  - IDLE: if enable, !i_stall, !i_flush and the head slot is valid, latch o_pref_addr <= head address, pop head, go to REQ; o_pref_req=1 from the next cycle. Latency from enqueue into an empty queue to o_pref_req is 2 cycles.
  - REQ: hold o_pref_req and o_pref_addr stable regardless of i_stall or enable. On i_pref_ack, o_issued_cnt increments and the FSM goes to IDLE. A new issue may start the cycle after the ack. On i_flush without ack, go to DRAIN.
  - DRAIN: hold the request until i_pref_ack, then go to IDLE without incrementing o_issued_cnt. Flush and ack in the same REQ cycle: go to IDLE, no increment.
- Flush: clears all valid bits, sets head = tail = 0, and any prediction in the same cycle is discarded (flush wins). The handshake is never aborted.
- Counters saturate at all ones.

Decomposition:
- Shared package riscv_jump_pred_pkg: state enum for IDLE/REQ/DRAIN and a queue-entry struct with valid and addr fields.
- One natural sub-module, riscv_jump_inject_fifo: the circular store with in-place invalidation, address-match compare and head skipping.
- The FSM and counters stay in the top module.

Test Plan:
- Inject 0x100 at pc 0x80, ack 1 cycle after req -> o_pref_req high 2 cycles after capture with o_pref_addr=0x100; o_issued_cnt=1.
- Six distinct injects (0x200..0x214, step 4) on six new PCs with i_pref_ack tied 0 -> first issued and held, next 4 queued, 6th dropped; o_dropped_cnt=1.
- Inject 0x300 twice on different PCs while queued -> one entry only; o_dropped_cnt=0.
- Queue 0x400 with i_stall=1, then i_fetch_pc=0x400 -> entry invalidated, no request ever issued after the stall drops.
- Assert i_flush during REQ for 0x500, ack 3 cycles later -> o_pref_req and address held until ack, o_issued_cnt unchanged, queue empty afterwards.
- Assert reset mid-REQ -> o_pref_req=0 immediately (async), counters 0; first inject after reset behaves as in the first scenario.
